// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory read controller.
// Sequence positions are expressed as step counts after the redirect start cycle.
package idli_pkg;

    typedef enum logic [2:0] {
        SQI_IDLE,
        SQI_DESELECT,
        SQI_CMD,
        SQI_ADDR,
        SQI_DUMMY,
        SQI_STREAM
    } sqi_state_t;

    localparam logic [7:0] SQI_CMD_READ    = 8'h03;
    localparam logic [3:0] SQI_STEP_CMD    = 4'd5;
    localparam logic [3:0] SQI_STEP_ADDR   = 4'd7;
    localparam logic [3:0] SQI_STEP_DUMMY  = 4'd13;
    localparam logic [3:0] SQI_STEP_STREAM = 4'd15;

    // Phase implied by a step count; step 0 only occurs before the first start.
    function automatic sqi_state_t sqi_state_of(input logic [3:0] step);
        if (step == 4'd0)                  return SQI_IDLE;
        else if (step < SQI_STEP_CMD)      return SQI_DESELECT;
        else if (step < SQI_STEP_ADDR)     return SQI_CMD;
        else if (step < SQI_STEP_DUMMY)    return SQI_ADDR;
        else if (step < SQI_STEP_STREAM)   return SQI_DUMMY;
        else                               return SQI_STREAM;
    endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI read controller: on a PC redirect, issues a quad READ with the fetch address and
// streams returned nibbles so the first one lands 16 cycles after the redirect start.
module idli_sqi_ctrl_m
    import idli_pkg::*;
(
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst,
    input  logic        i_sqi_redirect,
    input  logic [1:0]  i_sqi_ctr,
    input  logic [15:0] i_sqi_addr,
    input  logic [3:0]  i_sqi_sio_in,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output logic [3:0]  o_sqi_sio_out,
    output logic        o_sqi_sio_oe,
    output logic [3:0]  o_sqi_rd_data,
    output logic        o_sqi_rd_vld
);

    sqi_state_t  state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] addr_q;
    logic [3:0]  rd_data_q;
    logic        vld_q;
    logic        start;

    logic [23:0] byte_addr;
    logic [3:0]  addr_idx;
    logic [3:0]  addr_nibble;

    assign start = i_sqi_redirect && (i_sqi_ctr == 2'd0);

    always_comb begin
        step_d = step_q;
        if (start) begin
            step_d = 4'd1;
        end else if ((step_q != 4'd0) && (step_q != SQI_STEP_STREAM)) begin
            step_d = step_q + 4'd1;
        end
        state_d = sqi_state_of(step_d);
    end

    always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
        if (i_sqi_rst) begin
            state_q   <= SQI_IDLE;
            step_q    <= 4'd0;
            addr_q    <= 16'd0;
            rd_data_q <= 4'd0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            rd_data_q <= i_sqi_sio_in;
            // A restart must not let a stale stream's valid leak into k1.
            vld_q     <= !start && (step_q == SQI_STEP_STREAM);
            if (start) begin
                addr_q <= i_sqi_addr;
            end
        end
    end

    // Word address to byte address, sent MSB nibble first.
    assign byte_addr = {7'b0, addr_q, 1'b0};
    assign addr_idx  = step_q - SQI_STEP_ADDR;

    always_comb begin
        addr_nibble = 4'h0;
        case (addr_idx)
            4'd0:    addr_nibble = byte_addr[23:20];
            4'd1:    addr_nibble = byte_addr[19:16];
            4'd2:    addr_nibble = byte_addr[15:12];
            4'd3:    addr_nibble = byte_addr[11:8];
            4'd4:    addr_nibble = byte_addr[7:4];
            4'd5:    addr_nibble = byte_addr[3:0];
            default: addr_nibble = 4'h0;
        endcase
    end

    always_comb begin
        o_sqi_cs_n    = 1'b1;
        o_sqi_sio_oe  = 1'b0;
        o_sqi_sio_out = 4'h0;
        case (state_q)
            SQI_CMD: begin
                o_sqi_cs_n    = 1'b0;
                o_sqi_sio_oe  = 1'b1;
                o_sqi_sio_out = (step_q == SQI_STEP_CMD) ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0];
            end
            SQI_ADDR: begin
                o_sqi_cs_n    = 1'b0;
                o_sqi_sio_oe  = 1'b1;
                o_sqi_sio_out = addr_nibble;
            end
            SQI_DUMMY, SQI_STREAM: begin
                o_sqi_cs_n = 1'b0;
            end
            default: begin
                o_sqi_cs_n = 1'b1;
            end
        endcase
        o_sqi_sck_en = !o_sqi_cs_n;
    end

    assign o_sqi_rd_data = rd_data_q;
    assign o_sqi_rd_vld  = vld_q && !start;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: directed scenarios plus random redirects, checked every cycle
// against a model that tracks the cycle index since the last accepted redirect.
module tb_idli_sqi_ctrl_m;

    logic        gck = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [1:0]  ctr = 2'd0;
    logic [15:0] addr = 16'd0;
    logic [3:0]  sio_in = 4'd0;

    logic        cs_n;
    logic        sck_en;
    logic [3:0]  sio_out;
    logic        sio_oe;
    logic [3:0]  rd_data;
    logic        rd_vld;

    idli_sqi_ctrl_m dut (
        .i_sqi_gck      (gck),
        .i_sqi_rst      (rst),
        .i_sqi_redirect (redirect),
        .i_sqi_ctr      (ctr),
        .i_sqi_addr     (addr),
        .i_sqi_sio_in   (sio_in),
        .o_sqi_cs_n     (cs_n),
        .o_sqi_sck_en   (sck_en),
        .o_sqi_sio_out  (sio_out),
        .o_sqi_sio_oe   (sio_oe),
        .o_sqi_rd_data  (rd_data),
        .o_sqi_rd_vld   (rd_vld)
    );

    always #5 gck = ~gck;

    int checks = 0;
    int errors = 0;

    // Model: k = cycles since the accepted start (-1 = no sequence since reset).
    int          k = -1;
    logic [15:0] m_addr = 16'd0;
    logic [3:0]  m_rd = 4'd0;

    function automatic logic [3:0] exp_sio(input int kk, input logic [15:0] a);
        logic [31:0] w;
        w = {8'h03, 7'b0, a, 1'b0};
        if (kk >= 5 && kk <= 12) return w[31 - 4 * (kk - 5) -: 4];
        return 4'h0;
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        logic st;
        st = redirect && (ctr == 2'd0);
        check("cs_n",    {3'b0, cs_n},    {3'b0, !(k >= 5)});
        check("sck_en",  {3'b0, sck_en},  {3'b0, (k >= 5)});
        check("sio_oe",  {3'b0, sio_oe},  {3'b0, (k >= 5 && k <= 12)});
        check("sio_out", sio_out,         exp_sio(k, m_addr));
        check("rd_data", rd_data,         m_rd);
        check("rd_vld",  {3'b0, rd_vld},  {3'b0, (k >= 16) && !st});
    endtask

    // One cycle: drive inputs just after the edge, check at negedge, advance model at posedge.
    task automatic tick(input logic rd, input logic [15:0] a);
        logic [3:0] s;
        if (k >= 15 && k <= 18) s = 4'(10 + k - 15);
        else                    s = 4'($urandom);
        redirect = rd;
        addr     = a;
        sio_in   = s;
        @(negedge gck);
        check_all();
        @(posedge gck);
        if (redirect && ctr == 2'd0) begin
            k      = 1;
            m_addr = addr;
        end else if (k >= 0 && k < 1000) begin
            k++;
        end
        m_rd = sio_in;
        #1;
        ctr = ctr + 2'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'($urandom));
    endtask

    task automatic redirect_period(input logic [15:0] a);
        while (ctr != 2'd0) tick(1'b0, 16'($urandom));
        for (int i = 0; i < 4; i++) tick(1'b1, a);
    endtask

    // Redirect visible only at ctr 2 and 3; must never start a sequence.
    task automatic misaligned_redirect();
        while (ctr != 2'd2) tick(1'b0, 16'($urandom));
        tick(1'b1, 16'($urandom));
        tick(1'b1, 16'($urandom));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        k    = -1;
        m_rd = 4'd0;
        check("rst_cs_n",    {3'b0, cs_n},   4'd1);
        check("rst_oe",      {3'b0, sio_oe}, 4'd0);
        check("rst_sck_en",  {3'b0, sck_en}, 4'd0);
        check("rst_rd_vld",  {3'b0, rd_vld}, 4'd0);
        check("rst_rd_data", rd_data,        4'd0);
        @(posedge gck);
        #1;
        rst = 1'b0;
        ctr = ctr + 2'd1;
    endtask

    initial begin
        int r;
        repeat (2) @(posedge gck);
        #1;
        check("init_cs_n",    {3'b0, cs_n},   4'd1);
        check("init_oe",      {3'b0, sio_oe}, 4'd0);
        check("init_sio",     sio_out,        4'd0);
        check("init_rd_vld",  {3'b0, rd_vld}, 4'd0);
        check("init_rd_data", rd_data,        4'd0);
        rst = 1'b0;
        ctr = 2'd0;

        idle(20);

        redirect_period(16'h1234);
        idle(20);

        misaligned_redirect();
        idle(6);

        redirect_period(16'hFFFF);
        idle(20);

        redirect_period(16'hBEEF);
        while (k != 9) tick(1'b0, 16'($urandom));
        pulse_reset();
        idle(10);
        redirect_period(16'h0F0F);
        idle(20);

        for (int p = 0; p < 200; p++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2)      redirect_period(16'($urandom));
            else if (r == 3) misaligned_redirect();
            else if (r == 4) begin
                tick(1'b0, 16'($urandom));
                pulse_reset();
            end else         idle(4 + int'($urandom_range(0, 12)));
        end
        idle(24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
